// File: rtl/sata_cmd_fis_tx_if.sv
// Host command request, write-data, FIS stream and response stream of sata_cmd_fis_tx.
// The master modport is the command stage itself; slave is the surrounding host logic.
interface sata_cmd_fis_tx_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd;
  logic [15:0] i_features;
  logic [7:0]  i_device;
  logic [47:0] i_lba;
  logic [15:0] i_count;

  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [31:0] i_wr_data;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;

  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_status;
  logic [7:0]  o_error;
  logic        o_err;

  modport master (
    input  i_cmd_valid, i_cmd, i_features, i_device, i_lba, i_count,
    input  i_wr_valid, i_wr_data, m_ready, s_valid, s_data, s_last,
    output o_cmd_ready, o_wr_ready, m_valid, m_data, m_last, s_ready,
    output o_busy, o_done, o_status, o_error, o_err
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_features, i_device, i_lba, i_count,
    output i_wr_valid, i_wr_data, m_ready, s_valid, s_data, s_last,
    input  o_cmd_ready, o_wr_ready, m_valid, m_data, m_last, s_ready,
    input  o_busy, o_done, o_status, o_error, o_err
  );
endinterface

// File: rtl/sata_cmd_fis_tx.sv
// Serialises one ATA command as an H2D Register FIS, streams DMA-write data FISes,
// then consumes the D2H Register FIS and reports status/error/completion.
module sata_cmd_fis_tx #(
  parameter int SECTOR_WORDS  = 4,
  parameter int MAX_FIS_WORDS = 2048,
  parameter int TIMEOUT       = 1024
) (
  input  logic               i_tx_clk,
  input  logic               i_reset,
  sata_cmd_fis_tx_if.master  bus
);

  typedef enum logic [2:0] {IDLE, CMD, DHDR, DATA, RESP, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  cmd_q, dev_q;
  logic [15:0] feat_q, count_q;
  logic [47:0] lba_q;
  logic [2:0]  word_idx;
  logic [31:0] remaining, chunk_left, chunk_size, tmo_cnt;
  logic        first_resp;
  logic [7:0]  status_q, error_q;
  logic        err_q;
  logic        m_fire, s_fire, is_dma_wr, timeout_hit;

  assign m_fire      = bus.m_valid && bus.m_ready;
  assign s_fire      = bus.s_valid && bus.s_ready;
  assign is_dma_wr   = ((cmd_q == 8'hCA) || (cmd_q == 8'h35) || (cmd_q == 8'h3D) ||
                        (cmd_q == 8'h57)) && (count_q != 16'h0);
  assign timeout_hit = (tmo_cnt == 32'(TIMEOUT - 1));
  assign chunk_size  = (remaining > 32'(MAX_FIS_WORDS)) ? 32'(MAX_FIS_WORDS) : remaining;

  always_ff @(posedge i_tx_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.i_cmd_valid) state_next = CMD;
      CMD:  if (m_fire && word_idx == 3'd4) state_next = is_dma_wr ? DHDR : RESP;
      DHDR: if (m_fire) state_next = DATA;
      DATA: if (m_fire && chunk_left == 32'd1) state_next = (remaining != 32'd0) ? DHDR : RESP;
      RESP: if ((s_fire && bus.s_last) || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, FIS bookkeeping and response capture; the RESP timer and
  // first-word flag are re-armed in every other state so RESP always starts fresh.
  always_ff @(posedge i_tx_clk) begin
    if (i_reset) begin
      cmd_q      <= '0;
      dev_q      <= '0;
      feat_q     <= '0;
      count_q    <= '0;
      lba_q      <= '0;
      word_idx   <= '0;
      remaining  <= '0;
      chunk_left <= '0;
      tmo_cnt    <= '0;
      first_resp <= 1'b1;
      status_q   <= '0;
      error_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state != RESP) begin
        tmo_cnt    <= '0;
        first_resp <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            cmd_q     <= bus.i_cmd;
            dev_q     <= bus.i_device;
            feat_q    <= bus.i_features;
            count_q   <= bus.i_count;
            lba_q     <= bus.i_lba;
            word_idx  <= '0;
            remaining <= 32'(bus.i_count) * 32'(SECTOR_WORDS);
            err_q     <= 1'b0;
          end
        end
        CMD: if (m_fire) word_idx <= word_idx + 3'd1;
        DHDR: begin
          if (m_fire) begin
            chunk_left <= chunk_size;
            remaining  <= remaining - chunk_size;
          end
        end
        DATA: if (m_fire) chunk_left <= chunk_left - 32'd1;
        RESP: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (s_fire && first_resp) begin
            first_resp <= 1'b0;
            if (bus.s_data[31:24] == 8'h34) begin
              status_q <= bus.s_data[15:8];
              error_q  <= bus.s_data[7:0];
            end else begin
              err_q <= 1'b1;
            end
          end
          if (!(s_fire && bus.s_last) && timeout_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.m_valid    = 1'b0;
    bus.m_data     = 32'h0;
    bus.m_last     = 1'b0;
    bus.o_wr_ready = 1'b0;
    bus.s_ready    = 1'b0;
    case (state)
      CMD: begin
        bus.m_valid = 1'b1;
        bus.m_last  = (word_idx == 3'd4);
        case (word_idx)
          3'd0:    bus.m_data = {8'h27, 8'h80, cmd_q, feat_q[7:0]};
          3'd1:    bus.m_data = {dev_q, lba_q[23:0]};
          3'd2:    bus.m_data = {feat_q[15:8], lba_q[47:24]};
          3'd3:    bus.m_data = {16'h0000, count_q};
          default: bus.m_data = 32'h0;
        endcase
      end
      DHDR: begin
        bus.m_valid = 1'b1;
        bus.m_data  = 32'h4600_0000;
      end
      DATA: begin
        bus.m_valid    = bus.i_wr_valid;
        bus.o_wr_ready = bus.m_ready;
        bus.m_data     = bus.i_wr_data;
        bus.m_last     = (chunk_left == 32'd1);
      end
      RESP: bus.s_ready = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_cmd_ready = (state == IDLE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = (state == DONE);
  assign bus.o_status    = status_q;
  assign bus.o_error     = error_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_sata_cmd_fis_tx.sv
// Directed bench for sata_cmd_fis_tx; the data-FIS limit is lowered to 8 words
// so that a 3-sector write splits into an 8-word and a 4-word Data FIS.
module tb_sata_cmd_fis_tx;
  localparam int TIMEOUT = 1024;

  logic i_tx_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wr_src[$];
  logic [31:0] rx_data[$];
  logic        rx_last[$];
  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic [31:0] ref_data[$];
  logic        ref_last[$];
  logic [31:0] resp_q[$];
  logic [31:0] mem[int];
  int          cyc;
  bit          seen_done;

  sata_cmd_fis_tx_if bus();

  sata_cmd_fis_tx #(.SECTOR_WORDS(4), .MAX_FIS_WORDS(8), .TIMEOUT(TIMEOUT)) dut (
    .i_tx_clk (i_tx_clk),
    .i_reset  (i_reset),
    .bus      (bus)
  );

  always #5 i_tx_clk = ~i_tx_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] feat, input logic [7:0] dev,
                               input logic [47:0] lba, input logic [15:0] count);
    @(negedge i_tx_clk);
    checkOutput("cmd_ready_idle", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = cmd;
    bus.i_features  = feat;
    bus.i_device    = dev;
    bus.i_lba       = lba;
    bus.i_count     = count;
    @(posedge i_tx_clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    checkOutput("busy_after_accept", bus.o_busy, 1);
    checkOutput("first_m_valid", bus.m_valid, 1);
  endtask

  task automatic exp_push(input logic [31:0] d, input logic l);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  task automatic exp_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    exp_data.delete();
    exp_last.delete();
    exp_push(w0, 0); exp_push(w1, 0); exp_push(w2, 0); exp_push(w3, 0); exp_push(32'h0, 1);
  endtask

  // Collects n_words accepted FIS words while feeding write data; with stall set,
  // m_ready and i_wr_valid are randomly gapped and stalled words must hold steady.
  task automatic run_tx(input int n_words, input bit stall, input string tag);
    int          n = 0;
    int          wr_idx = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 0;
    rx_data.delete();
    rx_last.delete();
    while (rx_data.size() < n_words && n < 4000) begin
      @(negedge i_tx_clk);
      n++;
      bus.m_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wr_idx < wr_src.size()) begin
        bus.i_wr_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.i_wr_data  = wr_src[wr_idx];
      end else begin
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = 32'h0;
      end
      #1;
      if (prev_stall && bus.m_valid) checkOutput({tag, "_stall_hold"}, bus.m_data, prev_data);
      if (bus.m_valid && bus.m_ready) begin
        rx_data.push_back(bus.m_data);
        rx_last.push_back(bus.m_last);
      end
      if (bus.i_wr_valid && bus.o_wr_ready) wr_idx++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
    checkOutput({tag, "_word_count"}, rx_data.size(), n_words);
  endtask

  task automatic compare_rx(input string tag);
    checkOutput({tag, "_len"}, rx_data.size(), exp_data.size());
    for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++)
      checkOutput($sformatf("%s_w%0d", tag, i), {rx_last[i], rx_data[i]}, {exp_last[i], exp_data[i]});
  endtask

  task automatic send_resp(input string tag);
    for (int i = 0; i < resp_q.size(); i++) begin
      int n = 0;
      bit taken = 0;
      while (!taken && n < 100) begin
        @(negedge i_tx_clk);
        n++;
        bus.m_ready    = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.s_valid    = 1'b1;
        bus.s_data     = resp_q[i];
        bus.s_last     = (i == resp_q.size() - 1);
        #1;
        if (bus.s_ready) taken = 1;
      end
      $display("[TB] %s response word 0x%08h", tag, bus.s_data);
      checkOutput({tag, "_resp_taken"}, taken, 1);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int n);
    bit found = 0;
    n = 0;
    while (!found && n < max_cyc) begin
      @(negedge i_tx_clk);
      n++;
      bus.s_valid    = 1'b0;
      bus.s_last     = 1'b0;
      bus.m_ready    = 1'b0;
      bus.i_wr_valid = 1'b0;
      #1;
      if (bus.o_done) found = 1;
    end
    checkOutput({tag, "_done"}, found, 1);
    @(negedge i_tx_clk);
    #1;
    checkOutput({tag, "_done_one_cycle"}, bus.o_done, 0);
    checkOutput({tag, "_back_idle"}, bus.o_cmd_ready, 1);
  endtask

  initial begin
    i_reset = 1'b1;
    bus.i_cmd_valid = 0; bus.i_cmd = 0; bus.i_features = 0; bus.i_device = 0;
    bus.i_lba = 0; bus.i_count = 0; bus.i_wr_valid = 0; bus.i_wr_data = 0;
    bus.m_ready = 0; bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0;
    repeat (3) @(negedge i_tx_clk);
    checkOutput("rst_m_valid", bus.m_valid, 0);
    checkOutput("rst_m_data", bus.m_data, 0);
    checkOutput("rst_m_last", bus.m_last, 0);
    checkOutput("rst_wr_ready", bus.o_wr_ready, 0);
    checkOutput("rst_s_ready", bus.s_ready, 0);
    checkOutput("rst_busy", bus.o_busy, 0);
    checkOutput("rst_done", bus.o_done, 0);
    checkOutput("rst_status", bus.o_status, 0);
    checkOutput("rst_error", bus.o_error, 0);
    checkOutput("rst_err", bus.o_err, 0);
    i_reset = 1'b0;

    // Non-data command, four-word response.
    wr_src.delete();
    exp_cmd(32'h2780E700, 32'h0, 32'h0, 32'h0);
    applyStimulus(8'hE7, 16'h0000, 8'h00, 48'h0, 16'h0000);
    run_tx(5, 0, "nd");
    compare_rx("nd");
    resp_q = '{32'h34007700, 32'h11111111, 32'h22222222, 32'h33333333};
    send_resp("nd");
    wait_done("nd", 50, cyc);
    checkOutput("nd_status", bus.o_status, 8'h77);
    checkOutput("nd_error", bus.o_error, 8'h00);
    checkOutput("nd_err", bus.o_err, 0);

    // WRITE DMA, 2 sectors at LBA 0x10: one Data FIS of 8 words.
    wr_src.delete();
    for (int k = 0; k < 8; k++) wr_src.push_back(32'hD000_0000 + k);
    exp_cmd(32'h2780CA00, 32'h40000010, 32'h0, 32'h00000002);
    exp_push(32'h46000000, 0);
    for (int k = 0; k < 8; k++) exp_push(32'hD000_0000 + k, k == 7);
    applyStimulus(8'hCA, 16'h0000, 8'h40, 48'h10, 16'd2);
    run_tx(14, 0, "wr");
    compare_rx("wr");
    ref_data = rx_data;
    ref_last = rx_last;
    for (int k = 0; k < 8; k++) mem[32'h10 * 4 + k] = rx_data[6 + k];
    checkOutput("mem_lba10_w0", mem[64], 32'hD0000000);
    checkOutput("mem_lba11_w3", mem[71], 32'hD0000007);
    resp_q = '{32'h34005004, 32'hDEADBEEF};
    send_resp("wr");
    wait_done("wr", 50, cyc);
    checkOutput("wr_status", bus.o_status, 8'h50);
    checkOutput("wr_error", bus.o_error, 8'h04);
    checkOutput("wr_err", bus.o_err, 0);

    // WRITE DMA EXT, 3 sectors: split into 8-word and 4-word Data FISes.
    wr_src.delete();
    for (int k = 0; k < 12; k++) wr_src.push_back(32'hA000_0000 + k);
    exp_cmd(32'h278035CD, 32'hE0789ABC, 32'hAB123456, 32'h00000003);
    exp_push(32'h46000000, 0);
    for (int k = 0; k < 8; k++) exp_push(32'hA000_0000 + k, k == 7);
    exp_push(32'h46000000, 0);
    for (int k = 8; k < 12; k++) exp_push(32'hA000_0000 + k, k == 11);
    applyStimulus(8'h35, 16'hABCD, 8'hE0, 48'h123456789ABC, 16'd3);
    run_tx(19, 0, "split");
    compare_rx("split");
    resp_q = '{32'h34004100};
    send_resp("split");
    wait_done("split", 50, cyc);
    checkOutput("split_status", bus.o_status, 8'h41);
    checkOutput("split_error", bus.o_error, 8'h00);

    // Same WRITE DMA under random backpressure must match the unstalled run.
    wr_src.delete();
    for (int k = 0; k < 8; k++) wr_src.push_back(32'hD000_0000 + k);
    exp_data = ref_data;
    exp_last = ref_last;
    applyStimulus(8'hCA, 16'h0000, 8'h40, 48'h10, 16'd2);
    run_tx(14, 1, "bp");
    compare_rx("bp");
    resp_q = '{32'h34005004};
    send_resp("bp");
    wait_done("bp", 50, cyc);
    checkOutput("bp_status", bus.o_status, 8'h50);

    // READ DMA EXT with no response: no data phase, then timeout.
    wr_src.delete();
    exp_cmd(32'h27802500, 32'h40000000, 32'h0, 32'h00000001);
    applyStimulus(8'h25, 16'h0000, 8'h40, 48'h0, 16'd1);
    run_tx(5, 0, "tmo");
    compare_rx("tmo");
    wait_done("tmo", TIMEOUT + 100, cyc);
    checkOutput("tmo_latency_in_range", (cyc >= TIMEOUT) && (cyc <= TIMEOUT + 2), 1);
    checkOutput("tmo_err", bus.o_err, 1);
    checkOutput("tmo_status_held", bus.o_status, 8'h50);

    // WRITE DMA with count 0 goes straight to RESP; single-word response of wrong type.
    exp_cmd(32'h2780CA00, 32'h0, 32'h0, 32'h0);
    applyStimulus(8'hCA, 16'h0000, 8'h00, 48'h0, 16'd0);
    run_tx(5, 0, "bad");
    compare_rx("bad");
    @(negedge i_tx_clk);
    bus.m_ready = 1'b0;
    #1;
    checkOutput("bad_resp_entry_s_ready", bus.s_ready, 1);
    checkOutput("bad_no_data_fis", bus.m_valid, 0);
    resp_q = '{32'h27000000};
    send_resp("bad");
    wait_done("bad", 50, cyc);
    checkOutput("bad_err", bus.o_err, 1);
    checkOutput("bad_status_held", bus.o_status, 8'h50);
    checkOutput("bad_error_held", bus.o_error, 8'h04);

    // Reset after 3 of 8 data words.
    wr_src.delete();
    for (int k = 0; k < 8; k++) wr_src.push_back(32'hD000_0000 + k);
    applyStimulus(8'hCA, 16'h0000, 8'h40, 48'h10, 16'd2);
    checkOutput("err_cleared_on_accept", bus.o_err, 0);
    run_tx(9, 0, "rst");
    @(negedge i_tx_clk);
    i_reset = 1'b1;
    bus.m_ready = 1'b0;
    bus.i_wr_valid = 1'b0;
    @(posedge i_tx_clk);
    #1;
    checkOutput("mid_rst_m_valid", bus.m_valid, 0);
    checkOutput("mid_rst_m_data", bus.m_data, 0);
    checkOutput("mid_rst_m_last", bus.m_last, 0);
    checkOutput("mid_rst_wr_ready", bus.o_wr_ready, 0);
    checkOutput("mid_rst_s_ready", bus.s_ready, 0);
    checkOutput("mid_rst_busy", bus.o_busy, 0);
    checkOutput("mid_rst_done", bus.o_done, 0);
    checkOutput("mid_rst_status", bus.o_status, 0);
    checkOutput("mid_rst_error", bus.o_error, 0);
    checkOutput("mid_rst_err", bus.o_err, 0);
    @(negedge i_tx_clk);
    i_reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(negedge i_tx_clk);
      #1;
      if (bus.o_done) seen_done = 1;
    end
    checkOutput("mid_rst_no_done", seen_done, 0);

    wr_src.delete();
    exp_cmd(32'h2780E700, 32'h0, 32'h0, 32'h0);
    applyStimulus(8'hE7, 16'h0000, 8'h00, 48'h0, 16'h0000);
    run_tx(5, 0, "post");
    compare_rx("post");
    resp_q = '{32'h34005000};
    send_resp("post");
    wait_done("post", 50, cyc);
    checkOutput("post_status", bus.o_status, 8'h50);
    checkOutput("post_err", bus.o_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
